fb_fetch: RTL

- Instruction-fetch stage; consumes the PC's current address and drives back its hold control (pc_write).
- Issues word-address reads to the instruction ROM over a ready/valid handshake.
- Buffers returned instructions with their PC in a small FIFO and presents them to decode with valid/ready.
- Sits between the PC register, the instruction memory and the IF/ID boundary; handles branch-redirect flush.

---
 rtl/fb_fetch_pkg.sv | 26 ++
 rtl/fb_fetch_fifo.sv | 64 ++++++
 rtl/fb_fetch.sv | 115 +++++++++++
 3 files changed

// File: rtl/fb_fetch_pkg.sv
// rtl/fb_fetch_pkg.sv - shared defines, FSM encoding and FIFO entry type for the fetch stage
`ifndef FB_DEFINES_V
`define FB_DEFINES_V
`define FB_32BITS 31:0
`define FB_FETCH_IDLE 2'd0
`define FB_FETCH_WAIT 2'd1
`define FB_FETCH_DROP 2'd2
`define FB_NOP 32'h00000013
`endif

package fb_fetch_pkg;

  // IDLE: nothing in flight; WAIT: response pending; DROP: pending response belongs to a flushed path
  typedef enum logic [1:0] {
    ST_IDLE = `FB_FETCH_IDLE,
    ST_WAIT = `FB_FETCH_WAIT,
    ST_DROP = `FB_FETCH_DROP
  } fetch_state_e;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [`FB_32BITS] pc;
    logic [`FB_32BITS] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fb_fetch_fifo.sv
// rtl/fb_fetch_fifo.sv - synchronous {pc, instr} buffer with push/pop/clear and occupancy count
module fb_fetch_fifo
  import fb_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [PTR_W:0] count_o
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o      = (count_q == DEPTH_C);
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];

  // A full buffer never accepts a push and an empty one never pops
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy only moves when exactly one of push/pop happens
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)
      count_d = count_q + (PTR_W + 1)'(1);
    else if (!do_push && do_pop)
      count_d = count_q - (PTR_W + 1)'(1);
  end

  // Pointer and count update; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: empty_o gates everything read from it
  always_ff @(posedge clk) begin
    if (do_push && !clear_i)
      mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fb_fetch.sv
// rtl/fb_fetch.sv - instruction fetch stage, one outstanding ROM read, buffered to decode; FB_FETCH_PERF_EN adds counters
module fb_fetch
  import fb_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int PTR_W      = 1
) (
  input  logic              clk,
  input  logic              fetch_reset,
  input  logic [`FB_32BITS] pc_addr,
  output logic              pc_write,
  output logic              imem_req,
  output logic [`FB_32BITS] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [`FB_32BITS] imem_rdata,
  input  logic              flush,
  output logic              if_valid,
  output logic [`FB_32BITS] if_instr,
  output logic [`FB_32BITS] if_pc,
  input  logic              id_ready
`ifdef FB_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W + 2)'(FIFO_DEPTH);

  fetch_state_e      state_q;
  logic [`FB_32BITS] req_pc_q;
  logic              accept, push, pop;
  logic              fifo_full, fifo_empty;
  logic [PTR_W:0]    fifo_count;
  logic [PTR_W+1:0]  occupancy;
  fetch_entry_t      push_entry, head;

  // Slots already spoken for: buffered entries plus the response in flight (or landing now)
  assign occupancy = {1'b0, fifo_count} + {{(PTR_W + 1){1'b0}}, (state_q == ST_WAIT)};

  assign imem_addr = pc_addr;
  assign imem_req  = !fetch_reset && !flush && (occupancy < DEPTH_W) &&
                     ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && imem_rvalid));
  assign accept    = imem_req && imem_ready;

  // PC advances on an accepted read, or loads the redirect target on flush
  assign pc_write  = fetch_reset || !(accept || flush);

  assign push = (state_q == ST_WAIT) && imem_rvalid && !flush && !fetch_reset && !fifo_full;
  assign pop  = !fifo_empty && id_ready && !flush;

  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = imem_rdata;

  assign if_valid = !fifo_empty;
  assign if_instr = fifo_empty ? '0 : head.instr;
  assign if_pc    = fifo_empty ? '0 : head.pc;

  fb_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk         (clk),
    .rst_i       (fetch_reset),
    .clear_i     (flush),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_data_o (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Request tracker: latches the accepted address and follows the single outstanding read
  always_ff @(posedge clk) begin
    if (fetch_reset) begin
      state_q  <= ST_IDLE;
      req_pc_q <= '0;
    end else begin
      if (accept) req_pc_q <= pc_addr;
      unique case (state_q)
        ST_IDLE: if (accept) state_q <= ST_WAIT;
        ST_WAIT: begin
          if (flush)
            state_q <= imem_rvalid ? ST_IDLE : ST_DROP;
          else if (imem_rvalid)
            state_q <= accept ? ST_WAIT : ST_IDLE;
        end
        ST_DROP: if (imem_rvalid) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FB_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Free-running event counters: buffered instructions and PC-hold cycles not caused by flush
  always_ff @(posedge clk) begin
    if (fetch_reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (pc_write && !flush) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
